button_debouncer: RTL and testbench

//  Debounces one already-synchronized level input (output of the 2+-flop synchronizer
//  for a push-button/switch pin). Qualifies a level only after it has been stable for

---
 rtl/button_debouncer_pkg.sv | 16 +
 rtl/button_repeat_timer.sv | 53 +++++
 rtl/button_debouncer.sv | 133 +++++++++++++
 tb/tb_button_debouncer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/button_debouncer_pkg.sv
// Shared types and helpers for button_debouncer: FSM state encoding and counter width helper.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    STABLE_IDLE   = 2'd0,
    SETTLE_ACTIVE = 2'd1,
    STABLE_ACTIVE = 2'd2,
    SETTLE_IDLE   = 2'd3
  } deb_state_e;

  // Bits needed to hold values 0..max_value inclusive.
  function automatic int unsigned count_width(input int unsigned max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/button_repeat_timer.sv
// Auto-repeat timer: first strobe DELAY cycles after i_start, then every PERIOD cycles
// while i_enable stays high. Dropping i_enable clears the count; resuming uses PERIOD.
module button_repeat_timer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned DELAY  = 8,
  parameter int unsigned PERIOD = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_start,
  output logic o_strobe
);

  localparam int unsigned CW = count_width((DELAY > PERIOD) ? DELAY : PERIOD);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD - 1);

  logic [CW-1:0] r_count;
  logic          r_in_period;
  logic          r_strobe;
  logic [CW-1:0] w_last;

  assign w_last = r_in_period ? PERIOD_LAST : DELAY_LAST;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count     <= '0;
      r_in_period <= 1'b0;
      r_strobe    <= 1'b0;
    end else if (i_start) begin
      r_count     <= '0;
      r_in_period <= 1'b0;
      r_strobe    <= 1'b0;
    end else if (!i_enable) begin
      // A later return to the held state continues at the repeat period, not the delay.
      r_count     <= '0;
      r_in_period <= 1'b1;
      r_strobe    <= 1'b0;
    end else if (r_count == w_last) begin
      r_count     <= '0;
      r_in_period <= 1'b1;
      r_strobe    <= 1'b1;
    end else begin
      r_count  <= r_count + CW'(1);
      r_strobe <= 1'b0;
    end
  end

  assign o_strobe = r_strobe;

endmodule

// File: rtl/button_debouncer.sv
// Debouncer for one synchronized button level: qualifies changes after STABLE_CYCLES equal
// samples, emits press/release strobes. Optional auto-repeat under BUTTON_REPEAT_EN.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter logic        IDLE_LEVEL    = 1'b0,
  parameter int unsigned REPEAT_DELAY  = 8,
  parameter int unsigned REPEAT_PERIOD = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_bit_in,
  output logic o_level_out,
  output logic o_pressed,
  output logic o_released,
  output logic o_repeat
);

  localparam int unsigned   CW       = count_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);

  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("button_debouncer: STABLE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("button_debouncer: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  deb_state_e    r_state, w_state_next;
  logic [CW-1:0] r_count, w_count_next, w_count_inc;
  logic          r_level, w_level_next;
  logic          r_pressed, w_pressed_next;
  logic          r_released, w_released_next;
  logic          w_active_in;

  assign w_active_in = (i_bit_in != IDLE_LEVEL);
  assign w_count_inc = (r_count == CNT_MAX) ? r_count : r_count + CW'(1);

  always_comb begin
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_level_next    = r_level;
    w_pressed_next  = 1'b0;
    w_released_next = 1'b0;
    case (r_state)
      STABLE_IDLE: begin
        if (w_active_in) begin
          w_state_next = SETTLE_ACTIVE;
          w_count_next = CW'(1);
        end
      end
      SETTLE_ACTIVE: begin
        if (!w_active_in) begin
          w_state_next = STABLE_IDLE;
          w_count_next = '0;
        end else if (r_count == CNT_LAST) begin
          w_state_next   = STABLE_ACTIVE;
          w_count_next   = '0;
          w_level_next   = ~IDLE_LEVEL;
          w_pressed_next = 1'b1;
        end else begin
          w_count_next = w_count_inc;
        end
      end
      STABLE_ACTIVE: begin
        if (!w_active_in) begin
          w_state_next = SETTLE_IDLE;
          w_count_next = CW'(1);
        end
      end
      SETTLE_IDLE: begin
        if (w_active_in) begin
          w_state_next = STABLE_ACTIVE;
          w_count_next = '0;
        end else if (r_count == CNT_LAST) begin
          w_state_next    = STABLE_IDLE;
          w_count_next    = '0;
          w_level_next    = IDLE_LEVEL;
          w_released_next = 1'b1;
        end else begin
          w_count_next = w_count_inc;
        end
      end
      default: begin
        w_state_next = STABLE_IDLE;
        w_count_next = '0;
        w_level_next = IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= STABLE_IDLE;
      r_count    <= '0;
      r_level    <= IDLE_LEVEL;
      r_pressed  <= 1'b0;
      r_released <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_level    <= w_level_next;
      r_pressed  <= w_pressed_next;
      r_released <= w_released_next;
    end
  end

  assign o_level_out = r_level;
  assign o_pressed   = r_pressed;
  assign o_released  = r_released;

`ifdef BUTTON_REPEAT_EN
  // Timer driven from next-state so its strobe lines up with the registered FSM outputs.
  logic w_timer_en;
  assign w_timer_en = (w_state_next == STABLE_ACTIVE);

  button_repeat_timer #(
    .DELAY  (REPEAT_DELAY),
    .PERIOD (REPEAT_PERIOD)
  ) u_repeat_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (w_timer_en),
    .i_start  (w_pressed_next),
    .o_strobe (o_repeat)
  );
`else
  assign o_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: per-cycle directed stimulus with hand-derived
// expected {level, pressed, released, repeat}; a separate monitor pops and compares.
module tb_button_debouncer;

`ifdef BUTTON_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic bit_in = 1'b1;
  logic lvl, prs, rel, rep;

  typedef struct {
    string      name;
    logic [3:0] exp;
  } exp_t;

  exp_t        sb[$];
  exp_t        cur;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc    = 0;

  always #5 clk = ~clk;

  button_debouncer #(
    .STABLE_CYCLES (4),
    .IDLE_LEVEL    (1'b0),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_bit_in    (bit_in),
    .o_level_out (lvl),
    .o_pressed   (prs),
    .o_released  (rel),
    .o_repeat    (rep)
  );

  // One cycle: drive inputs before the edge, queue the outputs expected after it.
  task automatic step(input string name, input logic r, input logic b,
                      input logic el, input logic ep, input logic er, input logic erep);
    @(negedge clk);
    rst    = r;
    bit_in = b;
    sb.push_back('{name, {el, ep, er, erep}});
  endtask

  // Repeat expected k cycles after the pressed strobe: +8, then every 4.
  function automatic logic rep_exp(input int k);
    return REP_ON && (k >= 8) && (((k - 8) % 4) == 0);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() != 0) begin
        cur = sb.pop_front();
        checks++;
        if ({lvl, prs, rel, rep} !== cur.exp) begin
          errors++;
          $display("FAIL %s cycle %0d: level/pressed/released/repeat got %b expected %b",
                   cur.name, cyc, {lvl, prs, rel, rep}, cur.exp);
        end
      end
    end
  end

  initial begin
    repeat (3) step("reset_hold", 1, 1, 0, 0, 0, 0);
    repeat (2) step("idle_low", 0, 0, 0, 0, 0, 0);

    repeat (3) step("press_settle", 0, 1, 0, 0, 0, 0);
    step("press_edge", 0, 1, 1, 1, 0, 0);
    repeat (6) step("press_hold", 0, 1, 1, 0, 0, 0);

    repeat (3) step("release_settle", 0, 0, 1, 0, 0, 0);
    step("release_edge", 0, 0, 0, 0, 1, 0);
    repeat (2) step("release_after", 0, 0, 0, 0, 0, 0);

    repeat (3) step("short_pulse", 0, 1, 0, 0, 0, 0);
    repeat (3) step("short_after", 0, 0, 0, 0, 0, 0);

    step("bounce_1", 0, 1, 0, 0, 0, 0);
    step("bounce_1", 0, 1, 0, 0, 0, 0);
    step("bounce_0", 0, 0, 0, 0, 0, 0);
    step("bounce_1", 0, 1, 0, 0, 0, 0);
    step("bounce_1", 0, 1, 0, 0, 0, 0);
    step("bounce_1", 0, 1, 0, 0, 0, 0);
    step("bounce_press", 0, 1, 1, 1, 0, 0);

    for (int k = 1; k <= 30; k++) step("repeat_hold", 0, 1, 1, 0, 0, rep_exp(k));

    repeat (2) step("reset_mid_hold", 1, 1, 0, 0, 0, 0);
    repeat (3) step("repress_settle", 0, 1, 0, 0, 0, 0);
    step("repress_edge", 0, 1, 1, 1, 0, 0);

    repeat (2) step("rel_bounce_low", 0, 0, 1, 0, 0, 0);
    step("rel_bounce_high", 0, 1, 1, 0, 0, 0);
    repeat (3) step("rel_settle", 0, 0, 1, 0, 0, 0);
    step("rel_edge", 0, 0, 0, 0, 1, 0);

    repeat (2) step("settle_pre_reset", 0, 1, 0, 0, 0, 0);
    step("reset_mid_settle", 1, 1, 0, 0, 0, 0);
    repeat (4) step("post_reset_low", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
